// File: rtl/pop_count_block_acc.sv
// Accumulates per-word popcounts into blocks of up to BLOCK_LEN words and
// hands each block's sum, word count, maximum and clamp flag to a one-entry result register.
module pop_count_block_acc #(
    parameter int BLOCK_LEN = 16,
    parameter int SUM_W     = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [5:0]       in_cnt,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [SUM_W-1:0] out_sum,
    output logic [7:0]       out_words,
    output logic [5:0]       out_max,
    output logic             out_err
);

    localparam logic [7:0] LAST_IDX = 8'(BLOCK_LEN - 1);

    logic [SUM_W-1:0] acc_sum;
    logic [5:0]       acc_max;
    logic             acc_err;
    logic [7:0]       wcnt;

    logic             over;
    logic [5:0]       cnt_clamp;
    logic             accept;
    logic             close;
    logic [SUM_W-1:0] sum_next;
    logic [5:0]       max_next;
    logic             err_next;
    logic [7:0]       wcnt_next;

    // The result register can take a new block in the same cycle it drains.
    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign close    = accept && ((wcnt == LAST_IDX) || in_last);

    always_comb begin
        over      = (in_cnt > 6'd32);
        cnt_clamp = over ? 6'd32 : in_cnt;
        sum_next  = acc_sum + SUM_W'(cnt_clamp);
        max_next  = (cnt_clamp > acc_max) ? cnt_clamp : acc_max;
        err_next  = acc_err || over;
        wcnt_next = wcnt + 8'd1;
    end

    // Totals including the closing word go to the result register; the
    // accumulators restart from zero so no empty block can ever be formed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_sum <= '0;
            acc_max <= '0;
            acc_err <= 1'b0;
            wcnt    <= '0;
        end else if (close) begin
            acc_sum <= '0;
            acc_max <= '0;
            acc_err <= 1'b0;
            wcnt    <= '0;
        end else if (accept) begin
            acc_sum <= sum_next;
            acc_max <= max_next;
            acc_err <= err_next;
            wcnt    <= wcnt_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_words <= '0;
            out_max   <= '0;
            out_err   <= 1'b0;
        end else if (close) begin
            out_valid <= 1'b1;
            out_sum   <= sum_next;
            out_words <= wcnt_next;
            out_max   <= max_next;
            out_err   <= err_next;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pop_count_block_acc.sv
// Directed bench for pop_count_block_acc: reset, full and early-closed blocks,
// backpressure, back-to-back single-word blocks and clamping of illegal counts.
module tb_pop_count_block_acc;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [5:0] in_cnt = 6'd0;
    logic       in_last = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [9:0] out_sum;
    logic [7:0] out_words;
    logic [5:0] out_max;
    logic       out_err;

    int n_checks = 0;
    int n_fail   = 0;

    pop_count_block_acc #(.BLOCK_LEN(16), .SUM_W(10)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_cnt    (in_cnt),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_words (out_words),
        .out_max   (out_max),
        .out_err   (out_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send(input int cnt, input bit last);
        int waited;
        waited   = 0;
        in_valid = 1'b1;
        in_cnt   = 6'(cnt);
        in_last  = last;
        @(negedge clk);
        while (!in_ready && waited < 20) begin
            waited++;
            @(negedge clk);
        end
        if (!in_ready) check("send_timeout", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Result must be visible the cycle after the closing word and, with
    // out_ready high and nothing else closing, gone one cycle later.
    task automatic check_result(input string tag, input int sum, input int words,
                                input int mx, input int err);
        @(negedge clk);
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_sum"},   32'(out_sum),   32'(sum));
        check({tag, "_words"}, 32'(out_words), 32'(words));
        check({tag, "_max"},   32'(out_max),   32'(mx));
        check({tag, "_err"},   32'(out_err),   32'(err));
        @(negedge clk);
        check({tag, "_drop"},  32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Power-on reset
        #12;
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_sum",   32'(out_sum),   32'd0);
        check("rst_ready", 32'(in_ready),  32'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // One-word block, then a 5-word partial block killed by reset
        send(7, 1'b1);
        for (int i = 0; i < 5; i++) send(32, 1'b0);
        rst_n    = 1'b0;
        in_valid = 1'b1;
        in_cnt   = 6'd32;
        #2;
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_sum",   32'(out_sum),   32'd0);
        check("mid_rst_words", 32'(out_words), 32'd0);
        check("mid_rst_max",   32'(out_max),   32'd0);
        check("mid_rst_err",   32'(out_err),   32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        rst_n    = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 16; i++) send(2, 1'b0);
        check_result("post_rst", 32, 16, 2, 0);

        // Full block of maximum counts
        for (int i = 0; i < 16; i++) begin
            send(32, 1'b0);
            if (i == 7) check("full_mid_valid", 32'(out_valid), 32'd0);
        end
        check_result("full32", 512, 16, 32, 0);

        // Early close; in_last without in_valid must be ignored
        send(3, 1'b0);
        send(7, 1'b0);
        in_last = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        in_last = 1'b0;
        check("last_no_valid", 32'(out_valid), 32'd0);
        send(1, 1'b1);
        check_result("early3", 11, 3, 7, 0);
        for (int i = 0; i < 16; i++) send(1, 1'b0);
        check_result("ones16", 16, 16, 1, 0);

        // Backpressure: result held, input stalled, then drain + accept together
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(4, i == 3);
        in_valid = 1'b1;
        in_cnt   = 6'd10;
        in_last  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_ready",  32'(in_ready),  32'd0);
            check("bp_valid",  32'(out_valid), 32'd1);
            check("bp_sum",    32'(out_sum),   32'd16);
            check("bp_words",  32'(out_words), 32'd4);
            check("bp_max",    32'(out_max),   32'd4);
        end
        out_ready = 1'b1;
        #1;
        check("bp_release_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        check_result("bp_next", 10, 1, 10, 0);

        // Back-to-back single-word blocks
        in_valid = 1'b1;
        in_cnt   = 6'd5;
        in_last  = 1'b1;
        @(negedge clk);
        check("b2b_ready0", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_cnt = 6'd9;
        @(negedge clk);
        check("b2b_ready1", 32'(in_ready),  32'd1);
        check("b2b5_valid", 32'(out_valid), 32'd1);
        check("b2b5_sum",   32'(out_sum),   32'd5);
        check("b2b5_words", 32'(out_words), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        check_result("b2b9", 9, 1, 9, 0);

        // Illegal count clamped; in_last on the 16th word gives one block only
        send(40, 1'b0);
        for (int i = 0; i < 14; i++) send(0, 1'b0);
        send(0, 1'b1);
        check_result("clamp", 32, 16, 32, 1);
        send(3, 1'b1);
        check_result("after_clamp", 3, 1, 3, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
